// File: rtl/mem_access_ctrl_pkg.sv
// Shared load/store control codes and decode helpers for the M-stage memory access path.
// The op codes match the ALU control values driven by the pipeline decode stage.
package mem_access_ctrl_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } memSize_e;

    function automatic logic opIsValid(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic opIsStore(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic opIsSigned(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic memSize_e opSize(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic isAligned(input memSize_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~offset[0];
            default:   return (offset == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] storeStrobe(input memSize_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 4'b0001 << offset;
            SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Selects the addressed byte/half of a bus read word and sign- or zero-extends it.
module mem_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        signedOp;
    memSize_e    size;

    assign signedOp = opIsSigned(op);
    assign size     = opSize(op);

    always_comb begin
        byteSel = rdata[7:0];
        case (offset)
            2'd0: byteSel = rdata[7:0];
            2'd1: byteSel = rdata[15:8];
            2'd2: byteSel = rdata[23:16];
            2'd3: byteSel = rdata[31:24];
            default: byteSel = rdata[7:0];
        endcase
    end

    assign halfSel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data = rdata;
        case (size)
            SIZE_BYTE: data = signedOp ? {{24{byteSel[7]}}, byteSel} : {24'b0, byteSel};
            SIZE_HALF: data = signedOp ? {{16{halfSel[15]}}, halfSel} : {16'b0, halfSel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data memory access controller: launches one bus transaction per load/store,
// stalls the pipeline until it finishes, and returns the extended load result.
//
// state | meaning
// IDLE  | no transaction; a valid aligned, unflushed memory op launches this cycle
// ADDR  | data_req high with latched fields, waiting for data_addr_ok
// DATA  | address accepted, waiting for data_data_ok
// DONE  | result available; held while the pipeline is stalled elsewhere
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic [5:0]  alucontrolM,
    input  logic [31:0] addrM,
    input  logic [31:0] writedata2M,
    input  logic        flushM,
    input  logic        stallM_in,
    output logic        stallreqM,
    output logic [31:0] readdataM,
    output logic        adelM,
    output logic        adesM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state, stateNext;
    logic [5:0]  opReg;
    logic [1:0]  offReg;
    logic        flushPend;
    logic        flushNow;
    logic        reqValid, aligned, launch, complete;
    logic        storeM;
    memSize_e    sizeM;
    logic [31:0] extData;

    assign storeM   = opIsStore(alucontrolM);
    assign sizeM    = opSize(alucontrolM);
    assign aligned  = isAligned(sizeM, addrM[1:0]);

    // Errors and launches are only meaningful for the instruction seen while IDLE.
    assign reqValid = (state == IDLE) & memenM & ~flushM & opIsValid(alucontrolM) & ~rst;
    assign launch   = reqValid & aligned;
    assign adelM    = reqValid & ~aligned & ~storeM;
    assign adesM    = reqValid & ~aligned & storeM;

    assign stallreqM = launch | (state == ADDR) | (state == DATA);
    assign data_req  = (state == ADDR);

    assign flushNow = flushPend | flushM;
    assign complete = ((state == ADDR) & data_addr_ok & data_data_ok)
                    | ((state == DATA) & data_data_ok);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (launch) stateNext = ADDR;
            ADDR: begin
                if (data_addr_ok) begin
                    if (data_data_ok) stateNext = flushNow ? IDLE : DONE;
                    else              stateNext = DATA;
                end
            end
            DATA: if (data_data_ok) stateNext = flushNow ? IDLE : DONE;
            DONE: if (!stallM_in) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    mem_load_ext uLoadExt (
        .op     (opReg),
        .offset (offReg),
        .rdata  (data_rdata),
        .data   (extData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            opReg      <= 6'd0;
            offReg     <= 2'd0;
            flushPend  <= 1'b0;
            readdataM  <= 32'd0;
            data_wr    <= 1'b0;
            data_size  <= 2'd0;
            data_addr  <= 32'd0;
            data_wdata <= 32'd0;
            data_wstrb <= 4'd0;
        end else begin
            state <= stateNext;
            if (launch) begin
                opReg      <= alucontrolM;
                offReg     <= addrM[1:0];
                flushPend  <= 1'b0;
                data_wr    <= storeM;
                data_size  <= sizeM;
                data_addr  <= addrM;
                data_wdata <= writedata2M;
                data_wstrb <= storeM ? storeStrobe(sizeM, addrM[1:0]) : 4'b0000;
            end
            // A squash mid-transaction must outlive the flush pulse until data returns.
            if ((state == ADDR || state == DATA) && flushM)
                flushPend <= 1'b1;
            if (complete && !data_wr && !flushNow)
                readdataM <= extData;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed vector bench for mem_access_ctrl with a scripted bus slave.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        memenM;
    logic [5:0]  alucontrolM;
    logic [31:0] addrM;
    logic [31:0] writedata2M;
    logic        flushM;
    logic        stallM_in;
    logic        stallreqM;
    logic [31:0] readdataM;
    logic        adelM, adesM;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .alucontrolM  (alucontrolM),
        .addrM        (addrM),
        .writedata2M  (writedata2M),
        .flushM       (flushM),
        .stallM_in    (stallM_in),
        .stallreqM    (stallreqM),
        .readdataM    (readdataM),
        .adelM        (adelM),
        .adesM        (adesM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] expRd;
        logic [3:0]  expWstrb;
        logic [1:0]  expSize;
        logic        expWr;
        logic        expAdel;
        logic        expAdes;
        logic        flush;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int nVec = 0;
    int nMis = 0;
    int hsCount = 0;
    logic [31:0] lastRd;

    // Counts accepted address handshakes, i.e. bus requests actually issued.
    always @(posedge clk) if (data_req && data_addr_ok) hsCount <= hsCount + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [31:0] expRd, input logic [3:0] expWstrb,
                                input logic [1:0] expSize, input logic expWr,
                                input logic expAdel, input logic expAdes, input logic flush);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.expRd = expRd;
        v.expWstrb = expWstrb; v.expSize = expSize; v.expWr = expWr;
        v.expAdel = expAdel; v.expAdes = expAdes; v.flush = flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic runVec(input vec_t v, input int idx);
        logic       doLaunch;
        logic [31:0] expRead;
        string      nm;
        nm = $sformatf("vec%0d", idx);
        doLaunch = !(v.expAdel || v.expAdes || v.flush);
        memenM = 1'b1; alucontrolM = v.op; addrM = v.addr; writedata2M = v.wdata;
        flushM = v.flush;
        settle();
        chk({nm, " adelM"}, 32'(adelM), 32'(v.expAdel));
        chk({nm, " adesM"}, 32'(adesM), 32'(v.expAdes));
        chk({nm, " stallreqM launch"}, 32'(stallreqM), 32'(doLaunch));
        step();
        memenM = 1'b0; flushM = 1'b0;
        if (!doLaunch) begin
            settle();
            chk({nm, " no data_req"}, 32'(data_req), 32'd0);
            chk({nm, " readdataM held"}, readdataM, lastRd);
            step();
        end else begin
            settle();
            chk({nm, " data_req"}, 32'(data_req), 32'd1);
            chk({nm, " data_wstrb"}, 32'(data_wstrb), 32'(v.expWstrb));
            chk({nm, " data_size"}, 32'(data_size), 32'(v.expSize));
            chk({nm, " data_wr"}, 32'(data_wr), 32'(v.expWr));
            chk({nm, " data_addr"}, data_addr, v.addr);
            chk({nm, " data_wdata"}, data_wdata, v.wdata);
            data_addr_ok = 1'b1;
            step();
            data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = v.rdata;
            step();
            data_data_ok = 1'b0;
            expRead = v.expWr ? lastRd : v.expRd;
            settle();
            chk({nm, " stallreqM done"}, 32'(stallreqM), 32'd0);
            chk({nm, " readdataM"}, readdataM, expRead);
            lastRd = expRead;
            step();
        end
    endtask

    initial begin
        vecs[0]  = mk(OP_LW,  32'h100, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(OP_LB,  32'h201, 32'h0, 32'h12803456, 32'h00000034, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(OP_LB,  32'h202, 32'h0, 32'h12803456, 32'hFFFFFF80, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(OP_LBU, 32'h202, 32'h0, 32'h12803456, 32'h00000080, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(OP_LH,  32'h402, 32'h0, 32'h80017FFF, 32'hFFFF8001, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(OP_LHU, 32'h402, 32'h0, 32'h80017FFF, 32'h00008001, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(OP_LBU, 32'h203, 32'h0, 32'hAB000000, 32'h000000AB, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(OP_SB,  32'h103, 32'h5A5A5A5A, 32'h0, 32'h0, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(OP_SH,  32'h102, 32'h11223344, 32'h0, 32'h0, 4'b1100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(OP_SH,  32'h100, 32'h55667788, 32'h0, 32'h0, 4'b0011, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(OP_SW,  32'h104, 32'hCAFEBABE, 32'h0, 32'h0, 4'b1111, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(OP_SB,  32'h101, 32'h77777777, 32'h0, 32'h0, 4'b0010, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(OP_LW,  32'h302, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(OP_SH,  32'h301, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(OP_LH,  32'h401, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(OP_SW,  32'h106, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[16] = mk(OP_LW,  32'h302, 32'h0, 32'h0, 32'h0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[17] = mk(OP_LH,  32'h400, 32'h0, 32'h12345678, 32'h00005678, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; memenM = 1'b0; alucontrolM = 6'd0; addrM = 32'd0; writedata2M = 32'd0;
        flushM = 1'b0; stallM_in = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        data_rdata = 32'd0;
        lastRd = 32'd0;
        step(); step();
        settle();
        chk("reset data_req", 32'(data_req), 32'd0);
        chk("reset stallreqM", 32'(stallreqM), 32'd0);
        chk("reset readdataM", readdataM, 32'd0);
        chk("reset data_wstrb", 32'(data_wstrb), 32'd0);
        chk("reset adel/ades", 32'({adelM, adesM}), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NVEC; i++) runVec(vecs[i], i);

        // SB with slow slave: addr_ok in cycle 2, data_ok in cycle 4
        memenM = 1'b1; alucontrolM = OP_SB; addrM = 32'h103; writedata2M = 32'h5A5A5A5A;
        settle(); chk("sb c0 stallreqM", 32'(stallreqM), 32'd1);
        step(); memenM = 1'b0;
        settle(); chk("sb c1 stallreqM", 32'(stallreqM), 32'd1);
        chk("sb c1 data_req", 32'(data_req), 32'd1);
        chk("sb c1 data_wstrb", 32'(data_wstrb), 32'b1000);
        step(); data_addr_ok = 1'b1;
        settle(); chk("sb c2 stallreqM", 32'(stallreqM), 32'd1);
        chk("sb c2 data_req", 32'(data_req), 32'd1);
        step(); data_addr_ok = 1'b0;
        settle(); chk("sb c3 stallreqM", 32'(stallreqM), 32'd1);
        chk("sb c3 data_req", 32'(data_req), 32'd0);
        step(); data_data_ok = 1'b1;
        settle(); chk("sb c4 stallreqM", 32'(stallreqM), 32'd1);
        step(); data_data_ok = 1'b0;
        settle(); chk("sb done stallreqM", 32'(stallreqM), 32'd0);
        chk("sb done readdataM", readdataM, lastRd);
        step();

        // LH with addr_ok and data_ok in the same cycle
        memenM = 1'b1; alucontrolM = OP_LH; addrM = 32'h400;
        step(); memenM = 1'b0;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h00008001;
        settle(); chk("lh same data_req", 32'(data_req), 32'd1);
        step(); data_addr_ok = 1'b0; data_data_ok = 1'b0;
        settle(); chk("lh same stallreqM", 32'(stallreqM), 32'd0);
        chk("lh same data_req off", 32'(data_req), 32'd0);
        chk("lh same readdataM", readdataM, 32'hFFFF8001);
        lastRd = 32'hFFFF8001;
        step();

        // LW held in DONE by external stall; instruction stays valid in M
        begin
            int hs0;
            hs0 = hsCount;
            memenM = 1'b1; alucontrolM = OP_LW; addrM = 32'h500;
            step(); data_addr_ok = 1'b1;
            step(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600DF00D;
            stallM_in = 1'b1;
            step(); data_data_ok = 1'b0;
            for (int i = 0; i < 4; i++) begin
                settle();
                chk($sformatf("lw hold%0d stallreqM", i), 32'(stallreqM), 32'd0);
                chk($sformatf("lw hold%0d data_req", i), 32'(data_req), 32'd0);
                chk($sformatf("lw hold%0d readdataM", i), readdataM, 32'h600DF00D);
                if (i == 3) stallM_in = 1'b0;
                step();
            end
            memenM = 1'b0;
            settle(); chk("lw after hold stallreqM", 32'(stallreqM), 32'd0);
            step();
            chk("lw single request", 32'(hsCount - hs0), 32'd1);
            lastRd = 32'h600DF00D;
        end

        // Flush while waiting for data: result discarded, back to IDLE directly
        memenM = 1'b1; alucontrolM = OP_LW; addrM = 32'h600;
        step(); memenM = 1'b0; data_addr_ok = 1'b1;
        step(); data_addr_ok = 1'b0; flushM = 1'b1;
        settle(); chk("flush data stallreqM", 32'(stallreqM), 32'd1);
        step(); flushM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        step(); data_data_ok = 1'b0;
        memenM = 1'b1; alucontrolM = OP_LW; addrM = 32'h602;
        settle(); chk("flush idle adelM", 32'(adelM), 32'd1);
        chk("flush readdataM held", readdataM, lastRd);
        chk("flush idle stallreqM", 32'(stallreqM), 32'd0);
        step(); memenM = 1'b0;

        // Reset while requesting the address
        memenM = 1'b1; alucontrolM = OP_SW; addrM = 32'h700; writedata2M = 32'h13579BDF;
        step(); memenM = 1'b0;
        settle(); chk("rst addr data_req", 32'(data_req), 32'd1);
        rst = 1'b1;
        step();
        settle(); chk("rst after data_req", 32'(data_req), 32'd0);
        chk("rst after stallreqM", 32'(stallreqM), 32'd0);
        chk("rst after data_wstrb", 32'(data_wstrb), 32'd0);
        chk("rst after readdataM", readdataM, 32'd0);
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: memenM  in  1  M-stage memory instruction valid.
REQ-004 SHALL have: alucontrolM  in  6  load/store op (LB/LBU/LH/LHU/LW/SB/SH/SW control codes).
REQ-005 SHALL have: addrM  in  32  effective address.
REQ-006 SHALL have: writedata2M  in  32  lane-replicated store data.
REQ-007 SHALL have: flushM  in  1  squash M-stage instruction.
REQ-008 SHALL have: stallM_in  in  1  pipeline held by another source.
REQ-009 SHALL have: stallreqM  out  1  stall request to hazard unit.
REQ-010 SHALL have: readdataM  out  32  extended load result; adelM, adesM  out  1 each  load/store address error.
REQ-011 SHALL have bus side: data_req, data_wr out 1; data_size out 2; data_addr, data_wdata out 32; data_wstrb out 4; data_addr_ok, data_data_ok in 1; data_rdata in 32.

Function
REQ-012 SHALL implement FSM IDLE, ADDR, DATA, DONE.
REQ-013 IDLE: memenM & ~flushM & aligned -> latch op, addr[1:0], bus fields; go ADDR; stallreqM=1 same cycle (combinational).
REQ-014 ADDR: data_req=1, fields held stable; data_addr_ok -> DATA; addr_ok and data_ok same cycle -> treat as both, go DONE.
REQ-015 DATA: data_req=0; on data_data_ok capture data_rdata, go DONE.
REQ-016 stallreqM SHALL be 1 in ADDR and DATA and in IDLE cycle that launches; 0 in DONE.
REQ-017 DONE: readdataM valid; stallM_in=1 -> remain DONE; else -> IDLE. No request reissued for the same instruction.
REQ-018 data_size: byte ops 0, half 1, word 2; data_wr=1 for stores only; data_addr=addrM unmodified.
REQ-019 data_wstrb: SB 4'b0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111; loads 0000.
REQ-020 data_wdata SHALL equal writedata2M latched at launch.
REQ-021 Alignment: half ops need addr[0]=0, word ops addr[1:0]=0; violation -> adelM (load) or adesM (store) =1 combinationally, no bus request, no stall.
REQ-022 Load extension by latched addr[1:0]: LB sign-extend selected byte, LBU zero-extend, LH/LHU selected half sign/zero-extended, LW whole word.
REQ-023 readdataM SHALL be registered, updated only at load completion, held otherwise; stores leave it unchanged.
REQ-024 flushM in IDLE suppresses launch and errors; flushM during ADDR/DATA: transaction completes, result discarded, DATA -> IDLE skipping DONE.
REQ-025 One outstanding transaction maximum; memenM ignored outside IDLE.

Reset
REQ-026 rst SHALL force IDLE; data_req, stallreqM, adelM, adesM, data_wstrb, readdataM = 0 next edge.
REQ-027 rst mid-transaction SHALL abandon it; bus slave is reset by the same rst.

Structure
REQ-028 Op control codes SHALL come from the shared defines header used by the pipeline; FSM state encodings local.
REQ-029 Load extension SHALL be a combinational sub-module mem_load_ext (op, offset, rdata -> data).

Verification
REQ-030 SB, addrM=0x103, writedata2M=0x5A5A5A5A, addr_ok cycle 2, data_ok cycle 4 -> data_wstrb=1000, stallreqM high cycles 0-4, low in DONE.
REQ-031 LB, addrM=0x201, data_rdata=0x12_80_34_56 -> readdataM=0x00000034; LB addr 0x202 -> 0xFFFFFF80; LBU addr 0x202 -> 0x00000080.
REQ-032 LW addrM=0x302 -> adelM=1, data_req never asserted, stallreqM=0; SH addrM=0x301 -> adesM=1.
REQ-033 LH addrM=0x400, addr_ok and data_ok same cycle, rdata=0x0000_8001 -> DONE next cycle, readdataM=0xFFFF8001.
REQ-034 LW with stallM_in=1 for 3 cycles at completion -> held in DONE 3 cycles, single bus request total.
REQ-035 flushM asserted in DATA -> IDLE after data_ok, readdataM unchanged; rst asserted in ADDR -> data_req=0 next cycle.
